// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    // Receive FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_DATA_BITS    = 8;

    // Mid-bit sample point within a bit period (timer counts 1..CLKS_PER_BIT).
    localparam int HALF_BIT = DEF_CLKS_PER_BIT / 2;

    // Width of a counter that must reach DATA_BITS.
    localparam int BITCNT_W = $clog2(DEF_DATA_BITS + 1);

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int bitcnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter: counts 1..rollover_val while enabled, then wraps to 1.
// rollover_flag is high while count_out equals rollover_val. clear wins over count_enable.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic [NUM_CNT_BITS-1:0] w_next;

    // Next count: wrap to 1 after reaching the rollover value.
    always_comb begin
        w_next = r_count;
        if (count_enable) begin
            w_next = (r_count == rollover_val) ? NUM_CNT_BITS'(1) : r_count + 1'b1;
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_flag  <= (w_next == rollover_val);
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes the line, finds the start edge, samples each bit
// mid-period, assembles the word LSB first and presents it with status flags.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int TIMER_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int SAMPLE_PT = half_bit(CLKS_PER_BIT);
    localparam int BCW       = bitcnt_width(DATA_BITS);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync_prev;
    rx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_overrun;
    logic                 r_framing;

    logic                  w_sync;
    logic                  w_start_edge;
    logic [TIMER_BITS-1:0] w_tcount;
    logic                  w_bit_end;
    logic                  w_sample;
    logic [BCW-1:0]        w_bitcnt;
    logic                  w_bits_done;
    logic                  w_false_start;
    logic                  w_stop_fail;
    logic                  w_tmr_en;
    logic                  w_tmr_clr;
    logic                  w_bit_en;
    logic                  w_bit_clr;

    assign w_sync       = r_sync2;
    assign w_start_edge = r_sync_prev & ~r_sync2;
    assign w_sample     = (w_tcount == TIMER_BITS'(SAMPLE_PT));

    assign w_false_start = (r_state == START) & w_sample & w_sync;
    assign w_stop_fail   = (r_state == STOP) & w_sample & ~w_sync;

    // The start edge itself advances the timer so count 1 lands on E+1. Every
    // path back to IDLE also zeroes it, so an edge in the first IDLE cycle
    // (right after LOAD or a false start) still begins from a clean count.
    assign w_tmr_en  = (r_state != IDLE) | w_start_edge;
    assign w_tmr_clr = ((r_state == IDLE) & ~w_start_edge) | (r_state == LOAD) |
                       w_false_start | w_stop_fail;

    assign w_bit_en  = (r_state == DATA) & w_bit_end;
    assign w_bit_clr = (r_state == IDLE);

    flex_counter #(
        .NUM_CNT_BITS(TIMER_BITS)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_tmr_clr),
        .count_enable (w_tmr_en),
        .rollover_val (TIMER_BITS'(CLKS_PER_BIT)),
        .count_out    (w_tcount),
        .rollover_flag(w_bit_end)
    );

    flex_counter #(
        .NUM_CNT_BITS(BCW)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_bit_clr),
        .count_enable (w_bit_en),
        .rollover_val (BCW'(DATA_BITS)),
        .count_out    (w_bitcnt),
        .rollover_flag(w_bits_done)
    );

    // Two-flop synchronizer plus the previous-sample register for edge detect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= serial_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Frame FSM with shift register and registered host-side outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_shift      <= '1;
            r_rx_data    <= '0;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_framing    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= START;
                        r_framing <= 1'b0;
                    end
                end
                START: begin
                    if (w_false_start) begin
                        r_state <= IDLE;
                    end else if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    // The bit counter reports done one cycle after the last
                    // bit end, well before the stop-bit sample point.
                    if (w_bits_done) begin
                        r_state <= STOP;
                    end else if (w_sample && (w_bitcnt < BCW'(DATA_BITS))) begin
                        r_shift <= {w_sync, r_shift[DATA_BITS-1:1]};
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        if (!w_sync) begin
                            r_framing <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A load beats a same-cycle read; the read only consumes the old word.
            if (r_state == LOAD) begin
                r_rx_data    <= r_shift;
                r_data_ready <= 1'b1;
                if (data_read) begin
                    r_overrun <= 1'b0;
                end else if (r_data_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (data_read) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign overrun_error = r_overrun;
    assign framing_error = r_framing;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx_core;

    localparam int CPB           = 10;
    localparam int DB            = 8;
    localparam int TW            = 4;
    localparam int HALF          = CPB / 2;
    localparam int SYNC_LAT      = 2;                          // edges from line drop to start-edge cycle E
    localparam int STOP_SAMPLE_C = SYNC_LAT + 9 * CPB + HALF;  // cycle of the stop-bit sample
    localparam int READY_C       = STOP_SAMPLE_C + 2;          // data_ready visible
    localparam int FRAME_C       = 10 * CPB;                   // start + 8 data + stop

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic          data_read;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;

    int errors = 0;
    int checks = 0;

    // Reference model state (what the host should see).
    logic [DB-1:0] exp_data;
    logic          exp_ready;
    logic          exp_ovr;
    logic          exp_fe;

    uart_rx_core #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .TIMER_BITS  (TW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, ".data_ready"}, 32'(data_ready), 32'(exp_ready));
        chk({tag, ".overrun"}, 32'(overrun_error), 32'(exp_ovr));
        chk({tag, ".framing"}, 32'(framing_error), 32'(exp_fe));
    endtask

    task automatic model_reset();
        exp_data  = '0;
        exp_ready = 1'b0;
        exp_ovr   = 1'b0;
        exp_fe    = 1'b0;
    endtask

    // Drive one full frame starting at the current falling edge; optionally
    // pulse data_read during the LOAD cycle.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic rd_in_load, input string tag);
        logic [9:0] bits;
        logic       ready_before;
        bits         = {stop_bit, d, 1'b0};
        ready_before = exp_ready;
        for (int c = 1; c <= FRAME_C; c++) begin
            serial_in = bits[(c - 1) / CPB];
            data_read = rd_in_load && (c == READY_C);
            cyc();
            if (c == SYNC_LAT + 1)
                chk({tag, ".fe_clear_at_start"}, 32'(framing_error), 32'(0));
            if (c == READY_C - 1)
                chk({tag, ".ready_before_load"}, 32'(data_ready), 32'(ready_before));
            if ((c == READY_C) && stop_bit) begin
                chk({tag, ".ready_at_latency"}, 32'(data_ready), 32'(1));
                chk({tag, ".data_at_latency"}, 32'(rx_data), 32'(d));
            end
        end
        data_read = 1'b0;
        if (stop_bit) begin
            if (rd_in_load)     exp_ovr = 1'b0;
            else if (exp_ready) exp_ovr = 1'b1;
            exp_data  = d;
            exp_ready = 1'b1;
            exp_fe    = 1'b0;
        end else begin
            exp_fe = 1'b1;
            if (rd_in_load) begin
                exp_ready = 1'b0;
                exp_ovr   = 1'b0;
            end
        end
        check_all(tag);
        serial_in = 1'b1;
        repeat (3) cyc();
    endtask

    // Three low cycles then high: must be rejected, and the FSM must be ready
    // for a new start edge right after.
    task automatic false_start();
        for (int c = 1; c <= 6; c++) begin
            serial_in = (c <= 3) ? 1'b0 : 1'b1;
            cyc();
        end
        exp_fe = 1'b0;
        check_all("false_start");
    endtask

    task automatic read_pulse(input string tag);
        data_read = 1'b1;
        cyc();
        data_read = 1'b0;
        exp_ready = 1'b0;
        exp_ovr   = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [9:0]    bits;
        logic [DB-1:0] d;
        logic          stop_b;
        logic          rd;

        serial_in = 1'b1;
        data_read = 1'b0;
        n_rst     = 1'b1;
        model_reset();
        #2 n_rst = 1'b0;
        #1 check_all("reset");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) cyc();
        check_all("post_reset");

        send_frame(8'hA5, 1'b1, 1'b0, "a5");
        read_pulse("read_a5");

        false_start();
        send_frame(8'h96, 1'b1, 1'b0, "after_false_start");
        read_pulse("read_96");

        send_frame(8'h5A, 1'b0, 1'b0, "5a_bad_stop");
        send_frame(8'h3C, 1'b1, 1'b0, "3c");
        send_frame(8'hC3, 1'b1, 1'b0, "c3_overrun");
        read_pulse("read_overrun");

        send_frame(8'h11, 1'b1, 1'b0, "11");
        send_frame(8'h22, 1'b1, 1'b1, "22_read_in_load");

        for (int i = 0; i < 8; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            rd     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) false_start();
            send_frame(d, stop_b, rd, "rand");
            if ($urandom_range(0, 1) == 1) read_pulse("rand_read");
        end

        // Build up non-zero outputs, then reset in the middle of a frame.
        send_frame(8'h44, 1'b1, 1'b0, "pre_rst_a");
        send_frame(8'h55, 1'b1, 1'b0, "pre_rst_b");
        send_frame(8'h66, 1'b0, 1'b0, "pre_rst_bad");
        bits = {1'b1, 8'hFF, 1'b0};
        for (int c = 1; c <= SYNC_LAT + 5 * CPB + 3; c++) begin
            serial_in = bits[(c - 1) / CPB];
            cyc();
        end
        n_rst = 1'b0;
        model_reset();
        #1 check_all("midframe_reset");
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (12) cyc();
        check_all("after_midframe_reset");
        send_frame(8'h81, 1'b1, 1'b0, "81_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
